// File: rtl/prbs16_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prbs16_pkg
// Description : Shared constants for the PRBS16 checker and its LFSR block
// Revision    : 1.0 - initial release
// ============================================================================
package prbs16_pkg;

    localparam int c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_ST_SEARCH = 1'b0;
    localparam logic [c_STATE_W-1:0] c_ST_LOCKED = 1'b1;

    localparam int c_LFSR_W = 16;
    localparam int c_TAP_0  = 15;
    localparam int c_TAP_1  = 13;
    localparam int c_TAP_2  = 12;
    localparam int c_TAP_3  = 10;

endpackage
`default_nettype wire

// File: rtl/lsfr_16bit.sv
`default_nettype none
// ============================================================================
// Module      : lsfr_16bit
// Description : One step of the 16-bit Fibonacci LFSR: feedback bit and next state
// Revision    : 1.0 - initial release
// ============================================================================
module lsfr_16bit
    import prbs16_pkg::*;
(
    input  logic [c_LFSR_W-1:0] i_state,
    output logic                o_pred,
    output logic [c_LFSR_W-1:0] o_next
);

    assign o_pred = i_state[c_TAP_0] ^ i_state[c_TAP_1] ^ i_state[c_TAP_2] ^ i_state[c_TAP_3];
    assign o_next = {i_state[c_LFSR_W-2:0], o_pred};

endmodule
`default_nettype wire

// File: rtl/prbs16_checker.sv
`default_nettype none
// ============================================================================
// Module      : prbs16_checker
// Description : PRBS16 stream checker with lock search, windowed loss-of-lock
//               detection and saturating error / bit counters
// Revision    : 1.0 - initial release
// ============================================================================
module prbs16_checker
    import prbs16_pkg::*;
#(
    parameter int LOCK_COUNT = 32,
    parameter int WINDOW     = 256,
    parameter int ERR_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_valid,
    input  logic        din,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err,
    output logic        sync_loss,
    output logic [15:0] err_count,
    output logic [31:0] bit_count
);

    localparam int         c_MATCH_W   = $clog2(LOCK_COUNT + 1);
    localparam int         c_WBIT_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int         c_WERR_W    = $clog2(ERR_LIMIT + 1);
    localparam logic [4:0] c_FILL_FULL = 5'd16;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_next;
    logic [c_LFSR_W-1:0]  r_hist;
    logic [4:0]           r_fill;
    logic [c_MATCH_W-1:0] r_match;
    logic [c_WBIT_W-1:0]  r_win_bits;
    logic [c_WERR_W-1:0]  r_win_errs;
    logic                 r_locked;
    logic                 r_err;
    logic                 r_sync_loss;
    logic [15:0]          r_err_count;
    logic [31:0]          r_bit_count;

    logic                 w_pred;
    logic [c_LFSR_W-1:0]  w_lfsr_next;
    logic                 w_mismatch;
    logic [c_MATCH_W-1:0] w_match_inc;
    logic                 w_win_last;
    logic [c_WERR_W-1:0]  w_win_errs_inc;
    logic                 w_limit_hit;
    logic                 w_err_next;
    logic                 w_sync_loss_next;
    logic                 w_count_en;

    lsfr_16bit u_lfsr (
        .i_state (r_hist),
        .o_pred  (w_pred),
        .o_next  (w_lfsr_next)
    );

    assign w_mismatch     = din ^ w_pred;
    // Matches only count once the history is fully primed with a non-degenerate pattern
    assign w_match_inc    = ((r_fill == c_FILL_FULL) && (|r_hist) && !w_mismatch)
                            ? r_match + c_MATCH_W'(1) : '0;
    assign w_win_last     = (r_win_bits == c_WBIT_W'(WINDOW - 1));
    assign w_win_errs_inc = r_win_errs + c_WERR_W'(w_mismatch);
    assign w_limit_hit    = (w_win_errs_inc >= c_WERR_W'(ERR_LIMIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_SEARCH: begin
                if (din_valid && (w_match_inc == c_MATCH_W'(LOCK_COUNT))) begin
                    w_state_next = c_ST_LOCKED;
                end
            end
            c_ST_LOCKED: begin
                if (din_valid && w_mismatch && w_limit_hit) begin
                    w_state_next = c_ST_SEARCH;
                end
            end
            default: w_state_next = c_ST_SEARCH;
        endcase
    end

    always_comb begin
        w_err_next       = 1'b0;
        w_sync_loss_next = 1'b0;
        w_count_en       = 1'b0;
        if ((r_state == c_ST_LOCKED) && din_valid) begin
            w_count_en       = 1'b1;
            w_err_next       = w_mismatch;
            w_sync_loss_next = (w_state_next == c_ST_SEARCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win_bits  <= '0;
            r_win_errs  <= '0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_sync_loss <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            r_locked    <= (w_state_next == c_ST_LOCKED);
            r_err       <= w_err_next;
            r_sync_loss <= w_sync_loss_next;

            if (din_valid) begin
                if (r_state == c_ST_SEARCH) begin
                    r_hist  <= {r_hist[c_LFSR_W-2:0], din};
                    r_match <= (w_state_next == c_ST_LOCKED) ? '0 : w_match_inc;
                    if (r_fill != c_FILL_FULL) begin
                        r_fill <= r_fill + 5'd1;
                    end
                end else begin
                    // Free-running prediction so a single flipped input costs one error only
                    r_hist <= w_lfsr_next;
                    if (w_sync_loss_next) begin
                        r_fill     <= '0;
                        r_match    <= '0;
                        r_win_bits <= '0;
                        r_win_errs <= '0;
                    end else begin
                        r_win_bits <= w_win_last ? '0 : r_win_bits + c_WBIT_W'(1);
                        r_win_errs <= w_win_last ? '0 : w_win_errs_inc;
                    end
                end
            end

            if (clr_cnt) begin
                r_err_count <= '0;
                r_bit_count <= '0;
            end else begin
                if (w_err_next && (r_err_count != 16'hFFFF)) begin
                    r_err_count <= r_err_count + 16'd1;
                end
                if (w_count_en && (r_bit_count != 32'hFFFF_FFFF)) begin
                    r_bit_count <= r_bit_count + 32'd1;
                end
            end
        end
    end

    assign locked    = r_locked;
    assign err       = r_err;
    assign sync_loss = r_sync_loss;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule
`default_nettype wire
